// File: rtl/snake_tick_ctrl_if.sv
// Bundle between the input synchronizers / snake_core and the tick controller.
// The master side drives button levels and core status; the slave is the controller.
interface snake_tick_ctrl_if;
    logic       Left;
    logic       Right;
    logic       Up;
    logic       Down;
    logic       Pause;
    logic       Run;
    logic [3:0] Length;
    logic       Step;
    logic [1:0] Dir;
    logic       Paused;

    modport master (
        output Left, Right, Up, Down, Pause, Run, Length,
        input  Step, Dir, Paused
    );

    modport slave (
        input  Left, Right, Up, Down, Pause, Run, Length,
        output Step, Dir, Paused
    );
endinterface

// File: rtl/snake_tick_ctrl.sv
// Game-speed scheduler and direction arbiter for snake_core: issues the Step
// strobe at a length-dependent period and commits one non-reversing direction per Step.
module snake_tick_ctrl #(
    parameter int TICK_BASE = 12_500_000,
    parameter int TICK_DEC  = 500_000,
    parameter int TICK_MIN  = 3_000_000,
    parameter int CNT_W     = 24
) (
    input  logic            Clk,
    input  logic            Reset,
    snake_tick_ctrl_if.slave bus
);

    localparam int PW = CNT_W + 4;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_PAUSE = 2'b10
    } mode_t;

    mode_t            mode, mode_nxt;
    logic [3:0]       btn, prev_btn, btn_edge;
    logic             prev_pause, pause_edge;
    logic [CNT_W-1:0] cnt, reload;
    logic [PW-1:0]    prod, diff, period;
    logic             step_q, pend_valid;
    dir_t             dir_q, pend_dir, cand, opposite;
    logic             cand_valid, paused, fire, accept;

    assign btn        = {bus.Left, bus.Right, bus.Up, bus.Down};
    assign btn_edge   = btn & ~prev_btn;
    assign pause_edge = bus.Pause & ~prev_pause;
    assign paused     = (mode == MODE_PAUSE);

    // Period is recomputed every cycle but only loaded into cnt on a reload.
    always_comb begin
        prod   = PW'(bus.Length) * PW'(TICK_DEC);
        diff   = PW'(TICK_BASE) - prod;
        period = PW'(TICK_MIN);
        if (prod <= PW'(TICK_BASE) && diff > PW'(TICK_MIN)) begin
            period = diff;
        end
        reload = CNT_W'(period - PW'(1));
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cand       = DIR_LEFT;
        cand_valid = 1'b1;
        if      (btn_edge[3]) cand = DIR_LEFT;
        else if (btn_edge[2]) cand = DIR_RIGHT;
        else if (btn_edge[1]) cand = DIR_UP;
        else if (btn_edge[0]) cand = DIR_DOWN;
        else                  cand_valid = 1'b0;
    end

    // A reversal is judged against the committed heading only; it never falls through.
    assign opposite = dir_t'({dir_q[1], ~dir_q[0]});
    assign accept   = bus.Run && !paused && cand_valid && (cand != opposite);
    assign fire     = bus.Run && !paused && (cnt == '0);

    always_ff @(posedge Clk) begin
        if (Reset) mode <= MODE_IDLE;
        else       mode <= mode_nxt;
    end

    always_comb begin
        mode_nxt = mode;
        if (!bus.Run) begin
            mode_nxt = MODE_IDLE;
        end else begin
            case (mode)
                MODE_PAUSE: if (pause_edge) mode_nxt = MODE_RUN;
                default:    mode_nxt = pause_edge ? MODE_PAUSE : MODE_RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_btn   <= '0;
            prev_pause <= 1'b0;
            cnt        <= CNT_W'(TICK_BASE - 1);
            step_q     <= 1'b0;
            dir_q      <= DIR_RIGHT;
            pend_dir   <= DIR_RIGHT;
            pend_valid <= 1'b0;
        end else begin
            prev_btn   <= btn;
            prev_pause <= bus.Pause;
            step_q     <= fire;
            if (!bus.Run) begin
                cnt        <= reload;
                dir_q      <= DIR_RIGHT;
                pend_valid <= 1'b0;
            end else begin
                if (!paused) begin
                    cnt <= (cnt == '0) ? reload : cnt - 1'b1;
                end
                if (fire && pend_valid) begin
                    dir_q <= pend_dir;
                end
                // A request accepted on the Step edge survives for the next Step.
                if (accept) begin
                    pend_dir   <= cand;
                    pend_valid <= 1'b1;
                end else if (fire) begin
                    pend_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.Step   = step_q;
    assign bus.Dir    = dir_q;
    assign bus.Paused = paused;

endmodule

// File: tb/tb_snake_tick_ctrl.sv
// Self-checking bench for snake_tick_ctrl: segment table with hand-derived results,
// per-cycle scoreboard against a reference model, and hand-written corner sequences.
module tb_snake_tick_ctrl;

    localparam int TB_BASE = 10;
    localparam int TB_DEC  = 2;
    localparam int TB_MIN  = 4;
    localparam int TB_CW   = 8;

    logic Clk;
    logic Reset;

    snake_tick_ctrl_if bus();

    snake_tick_ctrl #(
        .TICK_BASE(TB_BASE),
        .TICK_DEC (TB_DEC),
        .TICK_MIN (TB_MIN),
        .CNT_W    (TB_CW)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       step;
        logic [1:0] dir;
        logic       paused;
    } exp_t;

    typedef struct {
        string      name;
        logic       run;
        logic [3:0] len;
        logic [3:0] btn;     // {Left, Right, Up, Down}, pulsed in the first cycle
        logic       pse;     // pulsed in the first cycle
        int         cycles;
        int         exp_steps;
        logic [1:0] exp_dir;
        logic       exp_paused;
    } seg_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   steps = 0;
    logic last_step;
    logic [1:0] last_dir;
    logic last_paused;

    // Reference model state: counts enabled edges up towards the latched period.
    logic       m_step, m_paused, m_pv;
    int         m_dir, m_pd, m_ticks, m_per;
    logic [3:0] m_prev;
    logic       m_pprev;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int period_of(input logic [3:0] len);
        int p;
        p = TB_BASE - int'(len) * TB_DEC;
        if (p < TB_MIN) p = TB_MIN;
        return p;
    endfunction

    task automatic model_update(input logic rst, input logic [3:0] b, input logic pse,
                                input logic run, input logic [3:0] len);
        logic [3:0] edges;
        logic       pedge, fire, accept;
        int         cand;
        if (rst) begin
            m_step = 0; m_dir = 1; m_paused = 0; m_pv = 0; m_pd = 1;
            m_ticks = 0; m_per = TB_BASE;
        end else begin
            edges = b & ~m_prev;
            pedge = pse & ~m_pprev;
            if (!run) begin
                m_step = 0; m_dir = 1; m_paused = 0; m_pv = 0;
                m_ticks = 0; m_per = period_of(len);
            end else begin
                fire   = !m_paused && (m_ticks == m_per - 1);
                accept = 0;
                cand   = 0;
                if (!m_paused && edges != 4'b0000) begin
                    cand   = edges[3] ? 0 : edges[2] ? 1 : edges[1] ? 2 : 3;
                    accept = (cand != (m_dir ^ 1));
                end
                m_step = fire;
                if (fire && m_pv) m_dir = m_pd;
                if (fire) m_pv = 0;
                if (accept) begin
                    m_pd = cand;
                    m_pv = 1;
                end
                if (!m_paused) begin
                    if (fire) begin
                        m_ticks = 0;
                        m_per   = period_of(len);
                    end else begin
                        m_ticks++;
                    end
                end
                if (pedge) m_paused = !m_paused;
            end
        end
        m_prev  = rst ? 4'b0000 : b;
        m_pprev = rst ? 1'b0 : pse;
    endtask

    // One clock: drive inputs, predict, then compare outputs away from the edge.
    task automatic cyc(input logic rst, input logic [3:0] b, input logic pse,
                       input logic run, input logic [3:0] len);
        exp_t e;
        Reset      = rst;
        bus.Left   = b[3];
        bus.Right  = b[2];
        bus.Up     = b[1];
        bus.Down   = b[0];
        bus.Pause  = pse;
        bus.Run    = run;
        bus.Length = len;
        model_update(rst, b, pse, run, len);
        e.step = m_step;
        e.dir = 2'(m_dir);
        e.paused = m_paused;
        exp_q.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
        e = exp_q.pop_front();
        last_step   = bus.Step;
        last_dir    = bus.Dir;
        last_paused = bus.Paused;
        if (last_step !== e.step || last_dir !== e.dir || last_paused !== e.paused) begin
            total++;
            bad++;
            $display("FAIL scoreboard t=%0t: got step=%b dir=%b paused=%b, expected step=%b dir=%b paused=%b",
                     $time, last_step, last_dir, last_paused, e.step, e.dir, e.paused);
        end else begin
            total++;
        end
        if (last_step === 1'b1) steps++;
    endtask

    task automatic idle_cycles(input int n, input logic run, input logic [3:0] len);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'b0000, 1'b0, run, len);
    endtask

    seg_t segs[22];

    initial begin
        segs[0]  = '{"base_period",    1'b1, 4'd1, 4'b0000, 1'b0,  8, 1, 2'b01, 1'b0};
        segs[1]  = '{"turn_up",        1'b1, 4'd1, 4'b0010, 1'b0,  8, 1, 2'b10, 1'b0};
        segs[2]  = '{"reverse_down",   1'b1, 4'd1, 4'b0001, 1'b0,  8, 1, 2'b10, 1'b0};
        segs[3]  = '{"left_pending",   1'b1, 4'd1, 4'b1000, 1'b0,  2, 0, 2'b10, 1'b0};
        segs[4]  = '{"right_overwr",   1'b1, 4'd1, 4'b0100, 1'b0,  6, 1, 2'b01, 1'b0};
        segs[5]  = '{"turn_up2",       1'b1, 4'd1, 4'b0010, 1'b0,  8, 1, 2'b10, 1'b0};
        segs[6]  = '{"left_right_sim", 1'b1, 4'd1, 4'b1100, 1'b0,  8, 1, 2'b00, 1'b0};
        segs[7]  = '{"reverse_right",  1'b1, 4'd1, 4'b0100, 1'b0,  8, 1, 2'b00, 1'b0};
        segs[8]  = '{"idle_dir",       1'b0, 4'd1, 4'b0000, 1'b0,  2, 0, 2'b01, 1'b0};
        segs[9]  = '{"left_up_sim",    1'b1, 4'd1, 4'b1010, 1'b0,  8, 1, 2'b01, 1'b0};
        segs[10] = '{"len5_reload",    1'b1, 4'd5, 4'b0000, 1'b0,  8, 1, 2'b01, 1'b0};
        segs[11] = '{"len5_sat",       1'b1, 4'd5, 4'b0000, 1'b0,  8, 2, 2'b01, 1'b0};
        segs[12] = '{"len_mid_change", 1'b1, 4'd1, 4'b0000, 1'b0,  2, 0, 2'b01, 1'b0};
        segs[13] = '{"len1_reload",    1'b1, 4'd1, 4'b0000, 1'b0,  8, 1, 2'b01, 1'b0};
        segs[14] = '{"len1_period",    1'b1, 4'd1, 4'b0000, 1'b0,  2, 1, 2'b01, 1'b0};
        segs[15] = '{"pre_pause",      1'b1, 4'd1, 4'b0000, 1'b0,  4, 0, 2'b01, 1'b0};
        segs[16] = '{"paused_hold",    1'b1, 4'd1, 4'b0000, 1'b1, 21, 0, 2'b01, 1'b1};
        segs[17] = '{"resume",         1'b1, 4'd1, 4'b0000, 1'b1,  3, 0, 2'b01, 1'b0};
        segs[18] = '{"resume_step",    1'b1, 4'd1, 4'b0000, 1'b0,  1, 1, 2'b01, 1'b0};
        segs[19] = '{"pre_abort",      1'b1, 4'd1, 4'b0010, 1'b0,  6, 0, 2'b01, 1'b0};
        segs[20] = '{"abort",          1'b0, 4'd1, 4'b0000, 1'b0,  1, 0, 2'b01, 1'b0};
        segs[21] = '{"restart_full",   1'b1, 4'd1, 4'b0000, 1'b0,  8, 1, 2'b01, 1'b0};

        // Reset, then one idle cycle so the counter reloads with P for Length=1.
        cyc(1'b1, 4'b0000, 1'b0, 1'b0, 4'd1);
        cyc(1'b1, 4'b0000, 1'b0, 1'b0, 4'd1);
        check("reset_step", int'(last_step), 0);
        check("reset_dir", int'(last_dir), 1);
        check("reset_paused", int'(last_paused), 0);
        idle_cycles(1, 1'b0, 4'd1);

        for (int i = 0; i < 22; i++) begin
            steps = 0;
            cyc(1'b0, segs[i].btn, segs[i].pse, segs[i].run, segs[i].len);
            idle_cycles(segs[i].cycles - 1, segs[i].run, segs[i].len);
            check({segs[i].name, "_steps"}, steps, segs[i].exp_steps);
            check({segs[i].name, "_dir"}, int'(last_dir), int'(segs[i].exp_dir));
            check({segs[i].name, "_paused"}, int'(last_paused), int'(segs[i].exp_paused));
        end

        // Request accepted on the Step edge is held for the following Step.
        steps = 0;
        idle_cycles(7, 1'b1, 4'd1);
        check("stepedge_pre_steps", steps, 0);
        cyc(1'b0, 4'b0010, 1'b0, 1'b1, 4'd1);
        check("stepedge_step", int'(last_step), 1);
        check("stepedge_dir_unchanged", int'(last_dir), 1);
        steps = 0;
        idle_cycles(8, 1'b1, 4'd1);
        check("stepedge_next_steps", steps, 1);
        check("stepedge_next_dir", int'(last_dir), 2);

        // Pending request survives a pause; requests during pause are dropped.
        steps = 0;
        cyc(1'b0, 4'b1000, 1'b0, 1'b1, 4'd1);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, 4'd1);
        check("pause_set", int'(last_paused), 1);
        cyc(1'b0, 4'b0100, 1'b0, 1'b1, 4'd1);
        idle_cycles(2, 1'b1, 4'd1);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, 4'd1);
        check("pause_clear", int'(last_paused), 0);
        idle_cycles(5, 1'b1, 4'd1);
        check("pause_pend_no_step", steps, 0);
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 4'd1);
        check("pause_pend_step", int'(last_step), 1);
        check("pause_pend_dir", int'(last_dir), 0);

        // Pause edge coincides with the Step-due cycle: Step fires, then Paused sets.
        idle_cycles(7, 1'b1, 4'd1);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, 4'd1);
        check("sim_pause_step", int'(last_step), 1);
        check("sim_pause_paused", int'(last_paused), 1);
        idle_cycles(1, 1'b1, 4'd1);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, 4'd1);
        check("sim_pause_resume", int'(last_paused), 0);

        // Reset on a Step-due cycle overrides it and restores Cnt to TICK_BASE-1.
        idle_cycles(7, 1'b1, 4'd1);
        cyc(1'b1, 4'b0000, 1'b0, 1'b1, 4'd1);
        check("reset_mid_step", int'(last_step), 0);
        check("reset_mid_dir", int'(last_dir), 1);
        check("reset_mid_paused", int'(last_paused), 0);
        steps = 0;
        idle_cycles(9, 1'b1, 4'd1);
        check("reset_mid_no_step", steps, 0);
        idle_cycles(1, 1'b1, 4'd1);
        check("reset_mid_base_step", int'(last_step), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
